uart_transceiver: RTL and testbench

- Byte-oriented 8N1 UART with 16x oversampling: baud tick generator, receiver and transmitter in one block.
- Serves as the host link of the encapsulation top level. Received bytes feed the TLV command decoder; the transmitter streams the 48-byte cycle-count report back.
- Transmitter and receiver share one oversampling tick.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_transceiver.sv | 208 ++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared defaults and FSM state encoding for the 8N1 UART transceiver.
package uart_pkg;

  localparam int unsigned DefDbits   = 8;
  localparam int unsigned DefSbTick  = 16;
  localparam int unsigned DefBrBits  = 6;
  localparam int unsigned DefBrLimit = 53;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running baud counter producing a one-clock oversampling tick at the terminal count.
module uart_baud_tick #(
  parameter int unsigned BR_BITS  = 6,
  parameter int unsigned BR_LIMIT = 53
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam logic [BR_BITS-1:0] Limit = BR_LIMIT[BR_BITS-1:0];

  logic [BR_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == Limit) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == Limit);

endmodule

// File: rtl/uart_transceiver.sv
// 8N1 UART with 16x oversampling; RX and TX FSMs share one baud tick and run fully independently.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned DBITS    = DefDbits,
  parameter int unsigned SB_TICK  = DefSbTick,
  parameter int unsigned BR_BITS  = DefBrBits,
  parameter int unsigned BR_LIMIT = DefBrLimit
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic             tx,
  input  logic             tx_start,
  input  logic [DBITS-1:0] data_in,
  output logic             tx_done,
  output logic             data_ready,
  output logic [DBITS-1:0] data_out,
  output logic             tick
);

  localparam int unsigned    NW    = $clog2(DBITS);
  localparam logic [NW-1:0]  NLast = NW'(DBITS - 1);
  localparam logic [3:0]     SLast = 4'(SB_TICK - 1);

  uart_baud_tick #(
    .BR_BITS  (BR_BITS),
    .BR_LIMIT (BR_LIMIT)
  ) u_baud (
    .clk_i  (clk),
    .rst_ni (reset),
    .tick_o (tick)
  );

  // Synchroniser resets to idle-high so reset release never looks like a start bit.
  logic [1:0] rx_sync_q;
  logic       rx_bit;
  assign rx_bit = rx_sync_q[1];

  uart_state_e      rx_state_q, rx_state_d;
  logic [3:0]       rx_s_q, rx_s_d;
  logic [NW-1:0]    rx_n_q, rx_n_d;
  logic [DBITS-1:0] rx_b_q, rx_b_d;
  logic             data_ready_q, data_ready_d;
  logic [DBITS-1:0] data_out_q, data_out_d;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_s_d       = rx_s_q;
    rx_n_d       = rx_n_q;
    rx_b_d       = rx_b_q;
    data_ready_d = 1'b0;
    data_out_d   = data_out_q;
    case (rx_state_q)
      StIdle: begin
        if (!rx_bit) begin
          rx_state_d = StStart;
          rx_s_d     = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (rx_s_q == 4'd7) begin
            rx_s_d     = '0;
            rx_n_d     = '0;
            rx_state_d = rx_bit ? StIdle : StData;
          end else begin
            rx_s_d = rx_s_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (rx_s_q == 4'd15) begin
            rx_s_d = '0;
            rx_b_d = {rx_bit, rx_b_q[DBITS-1:1]};
            if (rx_n_q == NLast) begin
              rx_state_d = StStop;
            end else begin
              rx_n_d = rx_n_q + 1'b1;
            end
          end else begin
            rx_s_d = rx_s_q + 4'd1;
          end
        end
      end
      StStop: begin
        // Stop-bit level is deliberately not checked.
        if (tick) begin
          if (rx_s_q == SLast) begin
            rx_state_d   = StIdle;
            data_ready_d = 1'b1;
            data_out_d   = rx_b_q;
          end else begin
            rx_s_d = rx_s_q + 4'd1;
          end
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  uart_state_e      tx_state_q, tx_state_d;
  logic [3:0]       tx_s_q, tx_s_d;
  logic [NW-1:0]    tx_n_q, tx_n_d;
  logic [DBITS-1:0] tx_b_q, tx_b_d;
  logic             tx_q, tx_d;
  logic             tx_done_q, tx_done_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      StIdle: begin
        if (tx_start) begin
          tx_b_d     = data_in;
          tx_s_d     = '0;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (tx_s_q == 4'd15) begin
            tx_s_d     = '0;
            tx_n_d     = '0;
            tx_state_d = StData;
          end else begin
            tx_s_d = tx_s_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (tx_s_q == 4'd15) begin
            tx_s_d = '0;
            tx_b_d = tx_b_q >> 1;
            if (tx_n_q == NLast) begin
              tx_state_d = StStop;
            end else begin
              tx_n_d = tx_n_q + 1'b1;
            end
          end else begin
            tx_s_d = tx_s_q + 4'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (tx_s_q == SLast) begin
            tx_state_d = StIdle;
            tx_done_d  = 1'b1;
          end else begin
            tx_s_d = tx_s_q + 4'd1;
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase

    // Line level follows the next state so tx changes on the same edge as the FSM.
    case (tx_state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = tx_b_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_sync_q    <= 2'b11;
      rx_state_q   <= StIdle;
      rx_s_q       <= '0;
      rx_n_q       <= '0;
      rx_b_q       <= '0;
      data_ready_q <= 1'b0;
      data_out_q   <= '0;
      tx_state_q   <= StIdle;
      tx_s_q       <= '0;
      tx_n_q       <= '0;
      tx_b_q       <= '0;
      tx_q         <= 1'b1;
      tx_done_q    <= 1'b0;
    end else begin
      rx_sync_q    <= {rx_sync_q[0], rx};
      rx_state_q   <= rx_state_d;
      rx_s_q       <= rx_s_d;
      rx_n_q       <= rx_n_d;
      rx_b_q       <= rx_b_d;
      data_ready_q <= data_ready_d;
      data_out_q   <= data_out_d;
      tx_state_q   <= tx_state_d;
      tx_s_q       <= tx_s_d;
      tx_n_q       <= tx_n_d;
      tx_b_q       <= tx_b_d;
      tx_q         <= tx_d;
      tx_done_q    <= tx_done_d;
    end
  end

  assign tx         = tx_q;
  assign tx_done    = tx_done_q;
  assign data_ready = data_ready_q;
  assign data_out   = data_out_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed self-checking bench for uart_transceiver at default parameters (864 clk per bit).
module tb_uart_transceiver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx;
  logic       tx;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx_done;
  logic       data_ready;
  logic [7:0] data_out;
  logic       tick;

  logic loop_en = 1'b0;
  logic rx_drv  = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_ready  = 0;
  int         done_cyc[$];
  int         ready_cyc[$];
  logic [7:0] rx_bytes[$];

  assign rx = loop_en ? tx : rx_drv;

  uart_transceiver dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .tx         (tx),
    .tx_start   (tx_start),
    .data_in    (data_in),
    .tx_done    (tx_done),
    .data_ready (data_ready),
    .data_out   (data_out),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) begin
      n_done++;
      done_cyc.push_back(cyc);
    end
    if (data_ready) begin
      n_ready++;
      ready_cyc.push_back(cyc);
      rx_bytes.push_back(data_out);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start a TX frame so that tx_start is sampled on a tick edge; returns that edge index.
  task automatic send_tx_aligned(input logic [7:0] b, output int e);
    bit found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tick) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("tick_for_tx_align", 32'(found), 32'd1);
    data_in  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    e = cyc;
  endtask

  task automatic send_rx(input logic [7:0] b, input int stop_low);
    rx_drv = 1'b0;
    repeat (864) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (864) @(negedge clk);
    end
    if (stop_low > 0) begin
      rx_drv = 1'b0;
      repeat (stop_low) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (864) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int e;
    int cnt;
    int d0;
    int r0;
    logic [7:0] bits;

    // Reset values
    repeat (4) @(negedge clk);
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_tx_done", 32'(tx_done), 32'd0);
    check_eq("rst_data_ready", 32'(data_ready), 32'd0);
    check_eq("rst_data_out", 32'(data_out), 32'd0);

    // Baud tick spacing
    reset = 1'b1;
    cnt = 1;
    while (!tick && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("first_tick_clk", 32'(cnt), 32'd54);
    for (int g = 0; g < 2; g++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
        if (cnt == 1) check_eq("tick_one_wide", 32'(tick), 32'd0);
      end while (!tick && cnt < 100);
      check_eq("tick_period", 32'(cnt), 32'd54);
    end

    // Loopback 0xA5: timing of start bit, data bits, tx_done and data_ready
    loop_en = 1'b1;
    done_cyc.delete(); ready_cyc.delete(); rx_bytes.delete();
    send_tx_aligned(8'hA5, e);
    check_eq("a5_start_low", 32'(tx), 32'd0);
    bits = 8'h00;
    for (int k = 1; k <= 8700; k++) begin
      @(negedge clk);
      if (k == 863) check_eq("a5_start_end", 32'(tx), 32'd0);
      if (k == 864) check_eq("a5_bit0_edge", 32'(tx), 32'd1);
      if (k >= 1296 && k <= 7344 && (k - 1296) % 864 == 0) bits[(k - 1296) / 864] = tx;
      if (k == 8208) check_eq("a5_stop_level", 32'(tx), 32'd1);
    end
    check_eq("a5_tx_bits", 32'(bits), 32'hA5);
    check_eq("a5_done_count", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check_eq("a5_done_latency", 32'(done_cyc[0] - e), 32'd8640);
    check_eq("a5_ready_count", 32'(ready_cyc.size()), 32'd1);
    if (ready_cyc.size() > 0) begin
      check_eq("a5_ready_latency", 32'(ready_cyc[0] - e), 32'd8208);
      check_eq("a5_rx_byte", 32'(rx_bytes[0]), 32'hA5);
    end

    // Start-bit glitch rejected, following frame received
    loop_en = 1'b0;
    r0 = n_ready;
    rx_drv = 1'b0;
    repeat (162) @(negedge clk);
    rx_drv = 1'b1;
    repeat (1000) @(negedge clk);
    check_eq("glitch_no_ready", 32'(n_ready - r0), 32'd0);
    send_rx(8'h3C, 0);
    check_eq("3c_ready_count", 32'(n_ready - r0), 32'd1);
    check_eq("3c_data_out", 32'(data_out), 32'h3C);

    // Low stop bit still delivers the byte
    r0 = n_ready;
    send_rx(8'h81, 524);
    repeat (1000) @(negedge clk);
    check_eq("81_ready_count", 32'(n_ready - r0), 32'd1);
    check_eq("81_data_out", 32'(data_out), 32'h81);

    // Held tx_start streams back-to-back frames
    loop_en = 1'b1;
    done_cyc.delete(); rx_bytes.delete();
    d0 = n_done;
    data_in  = 8'h00;
    tx_start = 1'b1;
    wait_done("stream_done0");
    data_in = 8'h01;
    wait_done("stream_done1");
    data_in = 8'h02;
    wait_done("stream_done2");
    tx_start = 1'b0;
    repeat (2000) @(negedge clk);
    check_eq("stream_done_count", 32'(n_done - d0), 32'd3);
    if (done_cyc.size() >= 3) begin
      check_eq("stream_gap01", 32'(done_cyc[1] - done_cyc[0]), 32'd8640);
      check_eq("stream_gap12", 32'(done_cyc[2] - done_cyc[1]), 32'd8640);
    end
    check_eq("stream_rx_count", 32'(rx_bytes.size()), 32'd3);
    for (int i = 0; i < 3 && i < rx_bytes.size(); i++) begin
      check_eq($sformatf("stream_rx_byte%0d", i), 32'(rx_bytes[i]), 32'(i));
    end
    check_eq("stream_idle_tx", 32'(tx), 32'd1);

    // Reset mid-DATA of both directions
    loop_en  = 1'b0;
    data_in  = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    rx_drv   = 1'b0;
    repeat (3000) @(negedge clk);
    check_eq("pre_reset_tx_low", 32'(tx), 32'd0);
    d0 = n_done;
    r0 = n_ready;
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_reset_tx", 32'(tx), 32'd1);
    check_eq("mid_reset_tx_done", 32'(tx_done), 32'd0);
    check_eq("mid_reset_data_ready", 32'(data_ready), 32'd0);
    check_eq("mid_reset_data_out", 32'(data_out), 32'd0);
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    reset  = 1'b1;
    repeat (200) @(negedge clk);
    loop_en = 1'b1;
    send_tx_aligned(8'h5A, e);
    repeat (8700) @(negedge clk);
    check_eq("post_reset_done_count", 32'(n_done - d0), 32'd1);
    check_eq("post_reset_ready_count", 32'(n_ready - r0), 32'd1);
    check_eq("post_reset_data_out", 32'(data_out), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
